// File: rtl/sevseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_scan_ctrl
//  Description : Time-multiplexed scan controller for common-anode seven-
//                segment digits sharing one hex decoder. Cycles an active-low
//                one-hot digit enable with dead time between digits, and
//                double-buffers the displayed value so that updates only take
//                effect on frame boundaries.
//                Optional build macro SEVSEG_LZ_BLANK_EN enables leading-zero
//                suppression on digits above digit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    ready,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [3:0]              hex,
    output logic                    blank,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [0:0] S_DEAD  = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    localparam logic [CNT_W-1:0] C_DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    // Double buffer and handshake
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;
    logic                    r_ready;

    // Registered outputs
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [3:0]            r_hex;
    logic                  r_blank;
    logic                  r_frame_done;

    // Next-state terms
    logic [0:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_wrap;
    logic                  w_accept;
    logic [NUM_DIGITS-1:0] w_supp;
    logic                  w_lit;
    logic [3:0]            w_nib;
    logic [NUM_DIGITS-1:0] w_an_nxt;

`ifdef SEVSEG_LZ_BLANK_EN
    // A digit above 0 is dark when it and every more significant nibble is 0
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz_digit
        if (k == 0) begin : g_lz_d0
            assign w_supp[k] = 1'b0;
        end else begin : g_lz_dk
            assign w_supp[k] = ~|r_active[4*NUM_DIGITS-1:4*k];
        end
    end
`else
    assign w_supp = '0;
`endif

    assign w_accept = load & r_ready;

    // Slot counter, digit index and DEAD/DRIVE sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        case (r_state)
            S_DEAD: begin
                if (r_cnt == C_DEAD_LAST) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == C_SLOT_LAST) begin
                    w_state_nxt = S_DEAD;
                    w_cnt_nxt   = '0;
                    if (r_idx == C_IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_DEAD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next scan position
    always_comb begin
        w_nib    = 4'h0;
        w_lit    = 1'b0;
        w_an_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(w_idx_nxt)) begin
                w_nib = r_active[4*k +: 4];
                w_lit = (w_state_nxt == S_DRIVE) && !w_supp[k];
                if (w_lit) begin
                    w_an_nxt[k] = 1'b0;
                end
            end
        end
    end

    // Scan state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_DEAD;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Load handshake and frame-aligned transfer from shadow to active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            if (w_wrap && r_pending) begin
                r_active <= r_shadow;
            end
            if (w_accept) begin
                r_shadow <= value;
            end
            // Pending is set only while ready, i.e. never together with a transfer
            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
            // Ready re-arms one cycle after the transfer clears pending
            if (w_accept) begin
                r_ready <= 1'b0;
            end else if (!r_pending) begin
                r_ready <= 1'b1;
            end
        end
    end

    // Registered pin-facing outputs; hex holds its value through dead time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_n       <= '1;
            r_hex        <= 4'h0;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an_n       <= w_an_nxt;
            r_blank      <= !w_lit;
            r_frame_done <= w_wrap;
            if (w_state_nxt == S_DRIVE) begin
                r_hex <= w_nib;
            end
        end
    end

    assign ready      = r_ready;
    assign an_n       = r_an_n;
    assign hex        = r_hex;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevseg_scan_ctrl
//  Description : Self-checking bench for sevseg_scan_ctrl. A timeline model
//                (cycle count since reset release) predicts digit enables,
//                blanking, frame pulses and the double-buffered value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sevseg_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int D  = 2;
    localparam int FR = N * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = 16'h0;
    logic          ready;
    logic [N-1:0]  an_n;
    logic [3:0]    hex;
    logic          blank;
    logic          frame_done;

    sevseg_scan_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .DEAD_CYCLES(D),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .ready     (ready),
        .an_n      (an_n),
        .hex       (hex),
        .blank     (blank),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    bit          m_pending;
    bit          m_ready;
    logic [3:0]  m_hex;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    function automatic bit suppressed(input int slot);
`ifdef SEVSEG_LZ_BLANK_EN
        return (slot > 0) && ((m_active >> (4 * slot)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_t       = 0;
        m_shadow  = 16'h0;
        m_active  = 16'h0;
        m_pending = 1'b0;
        m_ready   = 1'b1;
        m_hex     = 4'h0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an_n"},  32'(an_n),       32'hf);
        chk({tag, "_hex"},   32'(hex),        32'h0);
        chk({tag, "_blank"}, 32'(blank),      32'h1);
        chk({tag, "_ready"}, 32'(ready),      32'h1);
        chk({tag, "_fdone"}, 32'(frame_done), 32'h0);
    endtask

    task automatic check_outputs();
        int pos;
        int slot;
        bit drv;
        bit on;
        logic [N-1:0] exp_an;
        pos  = m_t % R;
        slot = (m_t / R) % N;
        drv  = (pos >= D);
        if (drv) m_hex = 4'((m_active >> (4 * slot)) & 16'hf);
        on     = drv && !suppressed(slot);
        exp_an = on ? ~(N'(1) << slot) : '1;
        chk("an_n",       32'(an_n),       32'(exp_an));
        chk("hex",        32'(hex),        32'(m_hex));
        chk("blank",      32'(blank),      32'(!on));
        chk("ready",      32'(ready),      32'(m_ready));
        chk("frame_done", 32'(frame_done), 32'((m_t > 0) && (m_t % FR == 0)));
    endtask

    // One clock: apply the handshake/frame rules for this edge, then compare
    task automatic step();
        bit acc;
        bit wrap;
        acc = load && m_ready;
        @(posedge clk);
        #1;
        wrap = ((m_t + 1) % FR == 0);
        if (acc)             m_ready = 1'b0;
        else if (!m_pending) m_ready = 1'b1;
        if (wrap && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (acc) begin
            m_shadow  = value;
            m_pending = 1'b1;
        end
        m_t++;
        check_outputs();
    endtask

    initial begin
        int guard;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Free-running scan showing zero, more than one frame
        repeat (40) step();

        // Mid-frame load, then a load while not ready (ignored)
        load = 1'b1; value = 16'h1A3F;
        step();
        load = 1'b0; value = 16'h0;
        repeat (3) step();
        load = 1'b1; value = 16'h5555;
        step();
        load = 1'b0;
        repeat (70) step();

        // Load landing on the frame wrap edge
        guard = 0;
        while (!(m_ready && (m_t % FR == FR - 1)) && guard < 200) begin
            step();
            guard++;
        end
        chk("wrap_align_timeout", 32'(guard < 200), 32'h1);
        load = 1'b1; value = 16'(($urandom & 32'hffff) | 32'h0100);
        step();
        load = 1'b0;
        repeat (70) step();

        // Randomized loads and values
        repeat (600) begin
            load  = ($urandom_range(0, 3) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00ff;
            step();
        end
        load = 1'b0;

`ifdef SEVSEG_LZ_BLANK_EN
        // Leading-zero patterns
        guard = 0;
        while (!m_ready && guard < 200) begin step(); guard++; end
        load = 1'b1; value = 16'h0030; step(); load = 1'b0;
        repeat (80) step();
        guard = 0;
        while (!m_ready && guard < 200) begin step(); guard++; end
        load = 1'b1; value = 16'h0000; step(); load = 1'b0;
        repeat (80) step();
`endif

        // Asynchronous reset during DRIVE of digit 2 with an update pending
        guard = 0;
        while (!m_ready && guard < 200) begin step(); guard++; end
        load = 1'b1; value = 16'hBEEF;
        step();
        load = 1'b0;
        guard = 0;
        while (!(m_pending && ((m_t / R) % N == 2) && (m_t % R >= D)) && guard < 200) begin
            step();
            guard++;
        end
        chk("drive2_timeout", 32'(guard < 200), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset("rst_async");
        @(posedge clk);
        #1 check_reset("rst_held");
        rst = 1'b0;
        model_reset();
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
